main_memory_unit: RTL and testbench
===================================

// Module: main_memory_unit
// PURPOSE
//   Main-memory slave that sits directly downstream of the cache controller FSM.
//   Accepts single-word read/write requests on the controller's memory strobe.
//   Models a fixed access latency with an internal down-counter.
//   Returns mem_done, the counter-expired signal the controller waits on in ReadMem/WriteMem.
// PARAMETERS
//   ADDR_W   8   word-address width; depth = 2**ADDR_W words
//   DATA_W   32  data word width
//   LATENCY  4   access cycles from accepted strobe to mem_done (legal range 1..255)
// PORTS
//   clk         in   1       single clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   mstrobe     in   1       request valid; sampled only in IDLE
//   mrw         in   1       1 = write, 0 = read
//   maddr       in   ADDR_W  word address
//   mwdata      in   DATA_W  write data
//   mrdata      out  DATA_W  read data; valid while mem_done=1 for a read
//   mem_done    out  1       one-cycle completion pulse
//   busy        out  1       high in ACCESS and DONE
//   ovr_err     out  1       sticky: mstrobe seen while busy
//   par_err     out  1       parity error on read (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0; all outputs 0 (mrdata, mem_done, busy, ovr_err, par_err).
//     Array contents are not reset.
//   States: IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE, mstrobe=1 at edge T0:
//     latch maddr/mrw/mwdata; cnt <= LATENCY-1; go ACCESS.
//   ACCESS: at each edge, if cnt==0 go DONE, else cnt <= cnt-1.
//     Write: the array write happens on the edge ACCESS->DONE.
//     Read: mrdata is loaded from the array on the edge ACCESS->DONE.
//   Latency: mem_done=1 exactly in the cycle after edge T0+LATENCY.
//     mem_done=1 for exactly one cycle; DONE -> IDLE unconditionally.
//   LATENCY=1: ACCESS lasts one cycle (cnt loaded 0).
//   mrdata holds its value until the next read completes; writes leave mrdata unchanged.
//   mstrobe in ACCESS or DONE: request ignored (no queueing); ovr_err <= 1.
//     ovr_err is cleared only by reset.
//   Back-to-back: the next strobe is accepted in IDLE, the cycle after mem_done.
//     Minimum period is LATENCY+2 cycles.
//   Latched request fields are immune to input changes after T0.
//   Reset mid-ACCESS: an in-flight write is dropped (array unchanged), no mem_done.
//     The block returns to IDLE immediately.
//   Read of a never-written word returns X in simulation; the bench must not check it.
// CONFIGURATION
//   MEM_PARITY_EN defined:
//     Array is DATA_W+1 wide; even parity over mwdata is stored on write.
//     On a read completion par_err=1 alongside mem_done if stored parity mismatches.
//     par_err is a one-cycle pulse, like mem_done.
//   MEM_PARITY_EN undefined: array is DATA_W wide; par_err tied 0.
// STRUCTURE
//   Package mem_pkg: mem_state_t enum {IDLE, ACCESS, DONE}; MEM_LATENCY_DEFAULT=4;
//     parity function even_par(data).
//   Sub-module mem_array: 2**ADDR_W x W synchronous single-port RAM
//     (we, addr, wdata, rdata registered).
//     W = DATA_W or DATA_W+1 depending on MEM_PARITY_EN.
//   The top holds the FSM, the counter, request latches and the error flags.
// TESTING
//   Write then read, LATENCY=4:
//     write addr 0x10 data 0xDEADBEEF -> mem_done in cycle T0+5.
//     Read addr 0x10 -> mrdata=0xDEADBEEF with mem_done, busy=1 for 5 cycles.
//   LATENCY=1: read -> mem_done in the cycle after T0+1; busy=1 exactly 2 cycles.
//   Strobe during ACCESS at a different addr -> ignored.
//     Original access completes unchanged; ovr_err=1 and stays 1.
//   Reset asserted mid-write to addr 0x20 (prior data 0x1):
//     outputs 0 immediately, no mem_done; later read of 0x20 returns 0x1.
//   Input change after strobe: mwdata changed at T0+1 -> stored value is the T0 value.
//   With MEM_PARITY_EN: flip a stored parity bit via hierarchical force, then read
//     -> par_err=1 with mem_done.
//     Clean read -> par_err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the main-memory slave: FSM states, default latency,
// and the even-parity helper used when the array carries a parity bit.
package mem_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;

   localparam int MEM_LATENCY_DEFAULT = 4;

   // Zero-extension of narrower words does not change the result.
   function automatic logic even_par(input logic [63:0] data);
      return ^data;
   endfunction
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 2**ADDR_W x W. The read register only loads on re,
// so it holds the last read word between accesses.
module mem_array #(
   parameter int ADDR_W = 8,
   parameter int W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [W-1:0]      wdata,
   output logic [W-1:0]      rdata
);
   logic [W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;

   always_ff @(posedge clk or posedge reset)
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[addr];
endmodule

// File: rtl/main_memory_unit.sv
// Main-memory slave with fixed access latency and one-cycle mem_done pulse.
// Optional feature: MEM_PARITY_EN stores an even-parity bit per word and flags read mismatches.
module main_memory_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mstrobe,
   input  logic              mrw,
   input  logic [ADDR_W-1:0] maddr,
   input  logic [DATA_W-1:0] mwdata,
   output logic [DATA_W-1:0] mrdata,
   output logic              mem_done,
   output logic              busy,
   output logic              ovr_err,
   output logic              par_err
);
`ifdef MEM_PARITY_EN
   localparam int W = DATA_W + 1;
`else
   localparam int W = DATA_W;
`endif

   mem_state_t        state;
   logic [7:0]        cnt;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [W-1:0]      arr_wdata;
   logic [W-1:0]      arr_rdata;
   logic              fire;

   // Array access happens on the same edge that moves ACCESS -> DONE.
   assign fire = (state == ACCESS) && (cnt == 8'd0);

`ifdef MEM_PARITY_EN
   assign arr_wdata = {even_par(64'(req_wdata)), req_wdata};
   assign par_err   = mem_done && !req_rw &&
                      (even_par(64'(arr_rdata[DATA_W-1:0])) != arr_rdata[DATA_W]);
`else
   assign arr_wdata = req_wdata;
   assign par_err   = 1'b0;
`endif

   assign mrdata = arr_rdata[DATA_W-1:0];

   mem_array #(.ADDR_W(ADDR_W), .W(W)) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (fire && req_rw),
      .re    (fire && !req_rw),
      .addr  (req_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         mem_done  <= 1'b0;
         ovr_err   <= 1'b0;
         req_rw    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
      end else begin
         mem_done <= 1'b0;
         case (state)
            IDLE: if (mstrobe) begin
               req_rw    <= mrw;
               req_addr  <= maddr;
               req_wdata <= mwdata;
               cnt       <= 8'(LATENCY - 1);
               busy      <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (mstrobe) ovr_err <= 1'b1;
               if (cnt == 8'd0) begin
                  mem_done <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            DONE: begin
               if (mstrobe) ovr_err <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_main_memory_unit.sv
// Scoreboard bench for main_memory_unit: dut0 at LATENCY=4, dut1 at LATENCY=1.
// Stimulus pushes expected completions; a negedge monitor pops and compares on mem_done.
module tb_main_memory_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        strobe [2];
   logic        rw     [2];
   logic [7:0]  addr   [2];
   logic [31:0] wdata  [2];
   logic [31:0] rdata  [2];
   logic        done   [2];
   logic        busy   [2];
   logic        ovr    [2];
   logic        par    [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      bit          rd;
      logic [31:0] data;
      int          cyc;
      bit          par;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   main_memory_unit #(.ADDR_W(8), .DATA_W(32), .LATENCY(4)) dut0 (
      .clk(clk), .reset(reset), .mstrobe(strobe[0]), .mrw(rw[0]), .maddr(addr[0]),
      .mwdata(wdata[0]), .mrdata(rdata[0]), .mem_done(done[0]), .busy(busy[0]),
      .ovr_err(ovr[0]), .par_err(par[0]));

   main_memory_unit #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .mstrobe(strobe[1]), .mrw(rw[1]), .maddr(addr[1]),
      .mwdata(wdata[1]), .mrdata(rdata[1]), .mem_done(done[1]), .busy(busy[1]),
      .ovr_err(ovr[1]), .par_err(par[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every completion must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      if (!reset) begin
         for (int s = 0; s < 2; s++) begin
            if (done[s]) begin
               have = (s == 0) ? (q0.size() > 0) : (q1.size() > 0);
               if (!have) begin
                  chk($sformatf("unexpected_done_dut%0d", s), 32'd1, 32'd0);
               end else begin
                  if (s == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  chk($sformatf("done_cyc_dut%0d", s), cyc, e.cyc);
                  chk($sformatf("mrdata_dut%0d", s), rdata[s], e.data);
                  chk($sformatf("par_err_dut%0d", s), {31'd0, par[s]}, {31'd0, e.par});
               end
            end
         end
      end
   end

   // One request; exp is the mrdata expected at completion (reads: the word, writes: unchanged).
   task automatic op(input int s, input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input bit pe, input bit inj, input int exp_busy);
      exp_t e;
      int   nb;
      bit   got;
      @(negedge clk);
      strobe[s] = 1'b1; rw[s] = w; addr[s] = a; wdata[s] = d;
      e.rd = !w; e.data = exp; e.par = pe;
      e.cyc = cyc + 1 + ((s == 0) ? 4 : 1);
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(negedge clk);
      strobe[s] = 1'b0; addr[s] = ~a; wdata[s] = ~d;
      nb  = busy[s];
      got = done[s];
      for (int i = 0; i < 40 && !got; i++) begin
         if (inj && i == 1) begin
            strobe[s] = 1'b1; rw[s] = 1'b1; addr[s] = a + 8'd1; wdata[s] = 32'h0BAD0BAD;
         end else begin
            strobe[s] = 1'b0;
         end
         @(negedge clk);
         nb += busy[s];
         got = done[s];
      end
      strobe[s] = 1'b0;
      if (!got) chk($sformatf("done_timeout_dut%0d", s), 32'd0, 32'd1);
      if (exp_busy > 0) chk($sformatf("busy_cycles_dut%0d", s), nb, exp_busy);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      for (int s = 0; s < 2; s++) begin
         strobe[s] = 1'b0; rw[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
      end
      repeat (2) @(negedge clk);
      chk("rst_mrdata", rdata[0], 32'h0);
      chk("rst_done", {31'd0, done[0]}, 32'd0);
      chk("rst_busy", {31'd0, busy[0]}, 32'd0);
      chk("rst_ovr", {31'd0, ovr[0]}, 32'd0);
      chk("rst_par", {31'd0, par[0]}, 32'd0);
      reset = 1'b0;

      op(0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        0, 0, 5);
      op(0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 0, 0, 5);
      op(0, 1'b1, 8'h30, 32'h12345678, 32'hDEADBEEF, 0, 0, 0);
      op(0, 1'b0, 8'h30, 32'h0,        32'h12345678, 0, 0, 0);
      op(0, 1'b1, 8'h40, 32'hCAFE0001, 32'h12345678, 0, 1, 0);
      chk("ovr_set", {31'd0, ovr[0]}, 32'd1);
      op(0, 1'b0, 8'h40, 32'h0,        32'hCAFE0001, 0, 0, 0);
      chk("ovr_sticky", {31'd0, ovr[0]}, 32'd1);
      op(0, 1'b1, 8'h20, 32'h00000001, 32'hCAFE0001, 0, 0, 0);
      op(0, 1'b0, 8'h20, 32'h0,        32'h00000001, 0, 0, 0);

      op(1, 1'b1, 8'h05, 32'hA5A5A5A5, 32'h0,        0, 0, 2);
      op(1, 1'b0, 8'h05, 32'h0,        32'hA5A5A5A5, 0, 0, 2);
      chk("ovr_clean_dut1", {31'd0, ovr[1]}, 32'd0);

      // Reset in the middle of a write: the write must not land and no completion appears.
      @(negedge clk);
      strobe[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 32'h00000055;
      @(negedge clk);
      strobe[0] = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
      chk("midrst_done", {31'd0, done[0]}, 32'd0);
      chk("midrst_mrdata", rdata[0], 32'h0);
      chk("midrst_ovr", {31'd0, ovr[0]}, 32'd0);
      chk("midrst_mrdata_dut1", rdata[1], 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      op(0, 1'b0, 8'h20, 32'h0, 32'h00000001, 0, 0, 5);
      op(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0);

`ifdef MEM_PARITY_EN
      op(0, 1'b1, 8'h50, 32'h0000000F, 32'hDEADBEEF, 0, 0, 0);
      dut0.u_array.mem[8'h50][32] = ~dut0.u_array.mem[8'h50][32];
      op(0, 1'b0, 8'h50, 32'h0, 32'h0000000F, 1, 0, 0);
      op(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0);
`endif

      repeat (3) @(negedge clk);
      chk("queues_drained", q0.size() + q1.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
